bram_arb: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 22 ++
 rtl/bram_arb_if.sv | 52 +++++
 rtl/bram_arb_slot.sv | 72 +++++++
 rtl/bram_arb.sv | 150 +++++++++++++++
 tb/tb_bram_arb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the bram_arb SRAM arbiter.
//   AW/DW/BW : macro word address width, data width, byte lane count
//   PORT_A/B : requester identifiers used in read-return tags
//   WEB_RD   : active-low byte enable pattern that encodes a read
//   tag_t    : in-flight read tag {vld, port}
package bram_arb_pkg;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [BW-1:0] WEB_RD = '1;

  typedef struct packed {
    logic vld;
    logic port;
  } tag_t;

endpackage

// File: rtl/bram_arb_if.sv
// Bus bundle for bram_arb: both requester ports, the SRAM macro side and the
// sticky overflow flags.
//   slave  : arbiter view (requests in, macro controls and read data out)
//   master : requester/macro-model view (the mirror image)
interface bram_arb_if;
  import bram_arb_pkg::*;

  logic          a_csb;
  logic [BW-1:0] a_web;
  logic [AW-1:0] a_adr;
  logic [DW-1:0] a_dti;
  logic [DW-1:0] a_dto;
  logic          a_bsy;
  logic          a_rvl;

  logic          b_csb;
  logic [BW-1:0] b_web;
  logic [AW-1:0] b_adr;
  logic [DW-1:0] b_dti;
  logic [DW-1:0] b_dto;
  logic          b_bsy;
  logic          b_rvl;

  logic          m_csb;
  logic [BW-1:0] m_web;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dti;
  logic [DW-1:0] m_dto;

  logic [1:0]    ovf;

  modport slave (
    input  a_csb, a_web, a_adr, a_dti,
    output a_dto, a_bsy, a_rvl,
    input  b_csb, b_web, b_adr, b_dti,
    output b_dto, b_bsy, b_rvl,
    output m_csb, m_web, m_adr, m_dti,
    input  m_dto,
    output ovf
  );

  modport master (
    output a_csb, a_web, a_adr, a_dti,
    input  a_dto, a_bsy, a_rvl,
    output b_csb, b_web, b_adr, b_dti,
    input  b_dto, b_bsy, b_rvl,
    input  m_csb, m_web, m_adr, m_dti,
    output m_dto,
    input  ovf
  );

endinterface

// File: rtl/bram_arb_slot.sv
// One-entry request holding slot for a single bram_arb requester port.
//   clk, rst         : clock, synchronous active-high reset
//   csb/web/adr/dti  : requester strobe (active low) and request payload
//   gnt              : arbiter grant for this port in the current cycle
//   done             : read data for this port's issued read returns this cycle
//   req_c, *_c       : pending request and its payload (held slot or bypass)
//   bsy              : slot occupied (registered)
//   ovf              : sticky dropped-request flag (registered)
module bram_arb_slot
  import bram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          csb,
  input  logic [BW-1:0] web,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] dti,
  input  logic          gnt,
  input  logic          done,
  output logic          req_c,
  output logic [BW-1:0] req_web_c,
  output logic [AW-1:0] req_adr_c,
  output logic [DW-1:0] req_dti_c,
  output logic          bsy,
  output logic          ovf
);

  logic          iss;
  logic [BW-1:0] web_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dti_q;
  logic          cap_c;

  // Capture is judged against the registered busy flag only.
  assign cap_c = !csb && !bsy;

  // An empty slot lets a new request bypass straight to the arbiter.
  assign req_c     = cap_c || (bsy && !iss);
  assign req_web_c = bsy ? web_q : web;
  assign req_adr_c = bsy ? adr_q : adr;
  assign req_dti_c = bsy ? dti_q : dti;

  // Slot state: writes retire the cycle after issue, reads on data return.
  always_ff @(posedge clk) begin
    if (rst) begin
      bsy   <= 1'b0;
      iss   <= 1'b0;
      web_q <= WEB_RD;
      adr_q <= '0;
      dti_q <= '0;
      ovf   <= 1'b0;
    end else begin
      if (cap_c) begin
        bsy   <= 1'b1;
        iss   <= gnt;
        web_q <= web;
        adr_q <= adr;
        dti_q <= dti;
      end else if (bsy) begin
        if (!iss) begin
          iss <= gnt;
        end else if ((web_q != WEB_RD) || done) begin
          bsy <= 1'b0;
        end
      end
      if (!csb && bsy) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_arb.sv
// Two-port arbiter sharing one single-port SRAM macro (port A: SPI bridge,
// port B: core load/store). Sequences macro accesses, tracks in-flight reads
// through a tag pipe and returns read data to the issuing port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bram_arb_if.slave (requester ports, macro side, ovf flags)
//   RDLAT    : macro read latency in cycles (1 or 2)
// Build option: define BRAM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority A over B.
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter int unsigned RDLAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  bram_arb_if.slave bus
);

  logic          req_a_c, req_b_c;
  logic          gnt_a_c, gnt_b_c;
  logic          done_a_c, done_b_c;
  logic [BW-1:0] web_a_c, web_b_c, sel_web_c;
  logic [AW-1:0] adr_a_c, adr_b_c, sel_adr_c;
  logic [DW-1:0] dti_a_c, dti_b_c, sel_dti_c;
  logic          ovf_a, ovf_b;

  // Entry 0 is aligned with the m_csb-low cycle, entry RDLAT with valid m_dto.
  tag_t [RDLAT:0] tag_sr;

  bram_arb_slot u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .csb       (bus.a_csb),
    .web       (bus.a_web),
    .adr       (bus.a_adr),
    .dti       (bus.a_dti),
    .gnt       (gnt_a_c),
    .done      (done_a_c),
    .req_c     (req_a_c),
    .req_web_c (web_a_c),
    .req_adr_c (adr_a_c),
    .req_dti_c (dti_a_c),
    .bsy       (bus.a_bsy),
    .ovf       (ovf_a)
  );

  bram_arb_slot u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .csb       (bus.b_csb),
    .web       (bus.b_web),
    .adr       (bus.b_adr),
    .dti       (bus.b_dti),
    .gnt       (gnt_b_c),
    .done      (done_b_c),
    .req_c     (req_b_c),
    .req_web_c (web_b_c),
    .req_adr_c (adr_b_c),
    .req_dti_c (dti_b_c),
    .bsy       (bus.b_bsy),
    .ovf       (ovf_b)
  );

`ifdef BRAM_ARB_RR_EN
  logic ptr;

  // Round-robin: preferred port wins a tie; any grant hands preference over.
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (req_a_c && req_b_c) begin
      gnt_a_c = (ptr == PORT_A);
      gnt_b_c = (ptr == PORT_B);
    end else begin
      gnt_a_c = req_a_c;
      gnt_b_c = req_b_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PORT_A;
    end else if (gnt_a_c) begin
      ptr <= PORT_B;
    end else if (gnt_b_c) begin
      ptr <= PORT_A;
    end
  end
`else
  // Fixed priority: A always wins.
  always_comb begin
    gnt_a_c = req_a_c;
    gnt_b_c = req_b_c && !req_a_c;
  end
`endif

  // Payload of the granted port.
  always_comb begin
    sel_web_c = web_a_c;
    sel_adr_c = adr_a_c;
    sel_dti_c = dti_a_c;
    if (gnt_b_c) begin
      sel_web_c = web_b_c;
      sel_adr_c = adr_b_c;
      sel_dti_c = dti_b_c;
    end
  end

  // Read return decode from the oldest tag.
  assign done_a_c = tag_sr[RDLAT].vld && (tag_sr[RDLAT].port == PORT_A);
  assign done_b_c = tag_sr[RDLAT].vld && (tag_sr[RDLAT].port == PORT_B);

  assign bus.ovf = {ovf_b, ovf_a};

  // Macro controls, tag pipe and read-data return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_csb <= 1'b1;
      bus.m_web <= WEB_RD;
      bus.m_adr <= '0;
      bus.m_dti <= '0;
      tag_sr    <= '0;
      bus.a_dto <= '0;
      bus.b_dto <= '0;
      bus.a_rvl <= 1'b0;
      bus.b_rvl <= 1'b0;
    end else begin
      bus.m_csb <= 1'b1;
      bus.m_web <= WEB_RD;
      if (gnt_a_c || gnt_b_c) begin
        bus.m_csb <= 1'b0;
        bus.m_web <= sel_web_c;
        bus.m_adr <= sel_adr_c;
        bus.m_dti <= sel_dti_c;
      end
      tag_sr <= {tag_sr[RDLAT-1:0],
                 tag_t'{vld:  (gnt_a_c || gnt_b_c) && (sel_web_c == WEB_RD),
                        port: gnt_b_c ? PORT_B : PORT_A}};
      bus.a_rvl <= done_a_c;
      bus.b_rvl <= done_b_c;
      if (done_a_c) begin
        bus.a_dto <= bus.m_dto;
      end
      if (done_b_c) begin
        bus.b_dto <= bus.m_dto;
      end
    end
  end

endmodule

// File: tb/tb_bram_arb.sv
// Directed bench for bram_arb: one instance with RDLAT=1, one with RDLAT=2,
// each attached to a simple byte-writable SRAM model. Read data is checked
// through per-port expected-data queues; timing is checked cycle by cycle.
module tb_bram_arb;
  import bram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_arb_if bus1 ();
  bram_arb_if bus2 ();

  bram_arb #(.RDLAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  bram_arb #(.RDLAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // SRAM models
  logic [DW-1:0] mem1 [0:2**AW-1] = '{default: '0};
  logic [DW-1:0] mem2 [0:2**AW-1] = '{default: '0};
  logic [DW-1:0] rd1  = '0;
  logic [DW-1:0] rd2a = '0;
  logic [DW-1:0] rd2b = '0;

  always @(posedge clk) begin
    if (!bus1.m_csb) begin
      if (bus1.m_web == WEB_RD) rd1 <= mem1[bus1.m_adr];
      else for (int k = 0; k < BW; k++)
        if (!bus1.m_web[k]) mem1[bus1.m_adr][k*8 +: 8] <= bus1.m_dti[k*8 +: 8];
    end
    if (!bus2.m_csb) begin
      if (bus2.m_web == WEB_RD) rd2a <= mem2[bus2.m_adr];
      else for (int k = 0; k < BW; k++)
        if (!bus2.m_web[k]) mem2[bus2.m_adr][k*8 +: 8] <= bus2.m_dti[k*8 +: 8];
    end
    rd2b <= rd2a;
  end
  assign bus1.m_dto = rd1;
  assign bus2.m_dto = rd2b;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  logic [DW-1:0] qa1 [$];
  logic [DW-1:0] qb1 [$];
  logic [DW-1:0] qa2 [$];
  logic [DW-1:0] qb2 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle1();
    bus1.a_csb = 1'b1; bus1.a_web = WEB_RD; bus1.a_adr = '0; bus1.a_dti = '0;
    bus1.b_csb = 1'b1; bus1.b_web = WEB_RD; bus1.b_adr = '0; bus1.b_dti = '0;
  endtask

  task automatic idle2();
    bus2.a_csb = 1'b1; bus2.a_web = WEB_RD; bus2.a_adr = '0; bus2.a_dti = '0;
    bus2.b_csb = 1'b1; bus2.b_web = WEB_RD; bus2.b_adr = '0; bus2.b_dti = '0;
  endtask

  task automatic req1(input logic port, input logic [BW-1:0] web,
                      input logic [AW-1:0] adr, input logic [DW-1:0] dti);
    if (port == PORT_A) begin
      bus1.a_csb = 1'b0; bus1.a_web = web; bus1.a_adr = adr; bus1.a_dti = dti;
    end else begin
      bus1.b_csb = 1'b0; bus1.b_web = web; bus1.b_adr = adr; bus1.b_dti = dti;
    end
  endtask

  task automatic req2(input logic port, input logic [BW-1:0] web,
                      input logic [AW-1:0] adr, input logic [DW-1:0] dti);
    if (port == PORT_A) begin
      bus2.a_csb = 1'b0; bus2.a_web = web; bus2.a_adr = adr; bus2.a_dti = dti;
    end else begin
      bus2.b_csb = 1'b0; bus2.b_web = web; bus2.b_adr = adr; bus2.b_dti = dti;
    end
  endtask

  // Read-return scoreboard: every x_rvl pulse pops the port's expected data.
  always @(negedge clk) begin
    if (bus1.a_rvl) begin
      if (qa1.size() == 0) chk("a1_rvl_unexpected", 64'(bus1.a_rvl), 64'd0);
      else chk("a1_dto", 64'(bus1.a_dto), 64'(qa1.pop_front()));
    end
    if (bus1.b_rvl) begin
      if (qb1.size() == 0) chk("b1_rvl_unexpected", 64'(bus1.b_rvl), 64'd0);
      else chk("b1_dto", 64'(bus1.b_dto), 64'(qb1.pop_front()));
    end
    if (bus2.a_rvl) begin
      if (qa2.size() == 0) chk("a2_rvl_unexpected", 64'(bus2.a_rvl), 64'd0);
      else chk("a2_dto", 64'(bus2.a_dto), 64'(qa2.pop_front()));
    end
    if (bus2.b_rvl) begin
      if (qb2.size() == 0) chk("b2_rvl_unexpected", 64'(bus2.b_rvl), 64'd0);
      else chk("b2_dto", 64'(bus2.b_dto), 64'(qb2.pop_front()));
    end
  end

  logic [AW-1:0] first_adr, second_adr;

  initial begin
    idle1();
    idle2();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_m_csb", 64'(bus1.m_csb), 64'd1);
    chk("rst_m_web", 64'(bus1.m_web), 64'hF);
    chk("rst_m_adr", 64'(bus1.m_adr), 64'd0);
    chk("rst_m_dti", 64'(bus1.m_dti), 64'd0);
    chk("rst_a_dto", 64'(bus1.a_dto), 64'd0);
    chk("rst_b_dto", 64'(bus1.b_dto), 64'd0);
    chk("rst_a_bsy", 64'(bus1.a_bsy), 64'd0);
    chk("rst_b_bsy", 64'(bus1.b_bsy), 64'd0);
    chk("rst_a_rvl", 64'(bus1.a_rvl), 64'd0);
    chk("rst_b_rvl", 64'(bus1.b_rvl), 64'd0);
    chk("rst_ovf",   64'(bus1.ovf),   64'd0);
    chk("rst2_m_csb", 64'(bus2.m_csb), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single A write, partial byte enables
    req1(PORT_A, 4'h7, 11'h010, 32'hAABBCCDD);
    @(negedge clk); idle1();                                  // cycle 1
    chk("wr_m_csb", 64'(bus1.m_csb), 64'd0);
    chk("wr_m_web", 64'(bus1.m_web), 64'h7);
    chk("wr_m_adr", 64'(bus1.m_adr), 64'h010);
    chk("wr_m_dti", 64'(bus1.m_dti), 64'hAABBCCDD);
    chk("wr_a_bsy_c1", 64'(bus1.a_bsy), 64'd1);
    @(negedge clk);                                           // cycle 2
    chk("wr_a_bsy_c2", 64'(bus1.a_bsy), 64'd0);
    chk("wr_m_csb_c2", 64'(bus1.m_csb), 64'd1);
    chk("wr_m_web_c2", 64'(bus1.m_web), 64'hF);
    chk("wr_m_adr_hold", 64'(bus1.m_adr), 64'h010);

    // Single B read of the partially written word
    req1(PORT_B, WEB_RD, 11'h010, 32'h0);
    qb1.push_back(32'hAA000000);
    @(negedge clk); idle1();                                  // cycle 1
    chk("rdb_m_csb", 64'(bus1.m_csb), 64'd0);
    chk("rdb_m_web", 64'(bus1.m_web), 64'hF);
    chk("rdb_m_adr", 64'(bus1.m_adr), 64'h010);
    chk("rdb_bsy_c1", 64'(bus1.b_bsy), 64'd1);
    @(negedge clk);                                           // cycle 2
    chk("rdb_bsy_c2", 64'(bus1.b_bsy), 64'd1);
    chk("rdb_rvl_c2", 64'(bus1.b_rvl), 64'd0);
    @(negedge clk);                                           // cycle 3
    chk("rdb_rvl_c3", 64'(bus1.b_rvl), 64'd1);
    chk("rdb_bsy_c3", 64'(bus1.b_bsy), 64'd0);
    chk("rdb_dto_c3", 64'(bus1.b_dto), 64'hAA000000);
    @(negedge clk);                                           // cycle 4
    chk("rdb_rvl_c4", 64'(bus1.b_rvl), 64'd0);
    chk("rdb_dto_hold", 64'(bus1.b_dto), 64'hAA000000);

    // Preload two words
    req1(PORT_A, 4'h0, 11'h020, 32'h11223344);
    @(negedge clk); idle1(); @(negedge clk);
    req1(PORT_B, 4'h0, 11'h030, 32'h55667788);
    @(negedge clk); idle1(); @(negedge clk);

    // Contention: both ports read in the same cycle
    req1(PORT_A, WEB_RD, 11'h020, 32'h0);
    req1(PORT_B, WEB_RD, 11'h030, 32'h0);
    qa1.push_back(32'h11223344);
    qb1.push_back(32'h55667788);
    @(negedge clk); idle1();                                  // cycle 1
    chk("con_m_csb_c1", 64'(bus1.m_csb), 64'd0);
    chk("con_m_adr_c1", 64'(bus1.m_adr), 64'h020);
    chk("con_b_bsy_c1", 64'(bus1.b_bsy), 64'd1);
    @(negedge clk);                                           // cycle 2
    chk("con_m_csb_c2", 64'(bus1.m_csb), 64'd0);
    chk("con_m_adr_c2", 64'(bus1.m_adr), 64'h030);
    @(negedge clk);                                           // cycle 3
    chk("con_a_rvl_c3", 64'(bus1.a_rvl), 64'd1);
    chk("con_b_rvl_c3", 64'(bus1.b_rvl), 64'd0);
    // New A request in the same cycle as a_rvl must be accepted
    req1(PORT_A, WEB_RD, 11'h010, 32'h0);
    qa1.push_back(32'hAA000000);
    @(negedge clk); idle1();                                  // cycle 4
    chk("con_b_rvl_c4", 64'(bus1.b_rvl), 64'd1);
    chk("con_a_rvl_c4", 64'(bus1.a_rvl), 64'd0);
    chk("con_reissue_csb", 64'(bus1.m_csb), 64'd0);
    chk("con_reissue_adr", 64'(bus1.m_adr), 64'h010);
    chk("con_ovf", 64'(bus1.ovf), 64'd0);
    repeat (3) @(negedge clk);

    // Overflow: second request while the slot is busy is dropped
    req1(PORT_A, WEB_RD, 11'h020, 32'h0);
    qa1.push_back(32'h11223344);
    @(negedge clk);                                           // cycle 1
    chk("ovf_a_bsy_c1", 64'(bus1.a_bsy), 64'd1);
    chk("ovf_pre", 64'(bus1.ovf), 64'd0);
    req1(PORT_A, WEB_RD, 11'h050, 32'h0);
    @(negedge clk); idle1();                                  // cycle 2
    chk("ovf_set", 64'(bus1.ovf), 64'd1);
    chk("ovf_not_issued", 64'(bus1.m_csb), 64'd1);
    chk("ovf_adr_hold", 64'(bus1.m_adr), 64'h020);
    @(negedge clk);                                           // cycle 3
    chk("ovf_a_bsy_c3", 64'(bus1.a_bsy), 64'd0);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 64'(bus1.ovf), 64'd1);
    chk("ovf_idle_csb", 64'(bus1.m_csb), 64'd1);
    chk("ovf_idle_bsy", 64'(bus1.a_bsy), 64'd0);

    // Priority: burst, single A, burst again
    req1(PORT_A, 4'h0, 11'h060, 32'h60606060);
    req1(PORT_B, 4'h0, 11'h070, 32'h70707070);
    @(negedge clk); idle1();
    chk("pri_burst1_first", 64'(bus1.m_adr), 64'h060);
    @(negedge clk);
    chk("pri_burst1_second", 64'(bus1.m_adr), 64'h070);
    @(negedge clk);
    req1(PORT_A, 4'h0, 11'h061, 32'h61616161);
    @(negedge clk); idle1();
    chk("pri_single_a", 64'(bus1.m_adr), 64'h061);
    repeat (2) @(negedge clk);
`ifdef BRAM_ARB_RR_EN
    first_adr  = 11'h072;
    second_adr = 11'h062;
`else
    first_adr  = 11'h062;
    second_adr = 11'h072;
`endif
    req1(PORT_A, 4'h0, 11'h062, 32'h62626262);
    req1(PORT_B, 4'h0, 11'h072, 32'h72727272);
    @(negedge clk); idle1();
    chk("pri_burst2_first", 64'(bus1.m_adr), 64'(first_adr));
    @(negedge clk);
    chk("pri_burst2_second", 64'(bus1.m_adr), 64'(second_adr));
    chk("pri_burst2_csb", 64'(bus1.m_csb), 64'd0);
    repeat (3) @(negedge clk);

    // Reset in the cycle after the read issues: the read never returns
    req1(PORT_A, WEB_RD, 11'h010, 32'h0);
    @(negedge clk); idle1();                                  // cycle 1
    chk("mrst_m_csb", 64'(bus1.m_csb), 64'd0);
    @(negedge clk);                                           // cycle 2
    rst = 1'b1;
    @(negedge clk);                                           // cycle 3
    chk("mrst_m_csb_c3", 64'(bus1.m_csb), 64'd1);
    chk("mrst_m_adr_c3", 64'(bus1.m_adr), 64'd0);
    chk("mrst_m_dti_c3", 64'(bus1.m_dti), 64'd0);
    chk("mrst_a_bsy_c3", 64'(bus1.a_bsy), 64'd0);
    chk("mrst_a_dto_c3", 64'(bus1.a_dto), 64'd0);
    chk("mrst_ovf_c3",   64'(bus1.ovf),   64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mrst_no_rvl", 64'(bus1.a_rvl), 64'd0);
      @(negedge clk);
    end

    // RDLAT=2: back-to-back reads A then B
    req2(PORT_A, 4'h0, 11'h100, 32'hDEADBEEF);
    @(negedge clk); idle2(); @(negedge clk);
    req2(PORT_B, 4'h0, 11'h101, 32'hCAFEF00D);
    @(negedge clk); idle2(); @(negedge clk);
    req2(PORT_A, WEB_RD, 11'h100, 32'h0);                     // cycle 0
    qa2.push_back(32'hDEADBEEF);
    @(negedge clk); idle2();                                  // cycle 1
    req2(PORT_B, WEB_RD, 11'h101, 32'h0);
    qb2.push_back(32'hCAFEF00D);
    chk("l2_m_adr_c1", 64'(bus2.m_adr), 64'h100);
    @(negedge clk); idle2();                                  // cycle 2
    chk("l2_m_adr_c2", 64'(bus2.m_adr), 64'h101);
    chk("l2_m_csb_c2", 64'(bus2.m_csb), 64'd0);
    @(negedge clk);                                           // cycle 3
    chk("l2_a_rvl_c3", 64'(bus2.a_rvl), 64'd0);
    @(negedge clk);                                           // cycle 4
    chk("l2_a_rvl_c4", 64'(bus2.a_rvl), 64'd1);
    chk("l2_b_rvl_c4", 64'(bus2.b_rvl), 64'd0);
    chk("l2_a_dto_c4", 64'(bus2.a_dto), 64'hDEADBEEF);
    @(negedge clk);                                           // cycle 5
    chk("l2_b_rvl_c5", 64'(bus2.b_rvl), 64'd1);
    chk("l2_a_rvl_c5", 64'(bus2.a_rvl), 64'd0);
    chk("l2_b_dto_c5", 64'(bus2.b_dto), 64'hCAFEF00D);
    repeat (3) @(negedge clk);

    // Every expected read must have come back
    chk("qa1_drained", 64'(qa1.size()), 64'd0);
    chk("qb1_drained", 64'(qb1.size()), 64'd0);
    chk("qa2_drained", 64'(qa2.size()), 64'd0);
    chk("qb2_drained", 64'(qb2.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
